// File: rtl/vending_machine.sv
// Purpose : coin-accumulating vending controller (Moore FSM). The price is 40 units
//           and the coins are worth 10, 20 or 50. Totals above 80 saturate at 80.
// Ports   : clk, reset (sync, active-high), coin[1:0] (00=10, 01=20, 10=50, 11=none),
//           Z (total >= 40), change_given (total > 40).
// Latency : outputs decode the registered state, one cycle after the sampling edge.
module vending_machine (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] coin,
    output logic       Z,
    output logic       change_given
);

    // The encoding equals the accumulated total divided by 10, so the adder
    // can work directly on the state value.
    typedef enum logic [3:0] {
        S0  = 4'd0,
        S10 = 4'd1,
        S20 = 4'd2,
        S30 = 4'd3,
        S40 = 4'd4,
        S50 = 4'd5,
        S60 = 4'd6,
        S70 = 4'd7,
        S80 = 4'd8
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] coin_val;
    logic [3:0] sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: add the coin value in tens and saturate at S80.
    always_comb begin
        coin_val = 4'd0;
        sum      = 4'd0;
        state_d  = S0;
        case (coin)
            2'b00:   coin_val = 4'd1;
            2'b01:   coin_val = 4'd2;
            2'b10:   coin_val = 4'd5;
            default: coin_val = 4'd0;
        endcase
        case (state_q)
            S0, S10, S20, S30, S40, S50, S60, S70, S80: begin
                // The largest sum is 8 + 5 = 13, which still fits in 4 bits.
                sum = state_q + coin_val;
                if (sum > 4'd8) begin
                    state_d = S80;
                end else begin
                    state_d = state_t'(sum);
                end
            end
            // Encodings 9..15 are unreachable. They recover to S0.
            default: state_d = S0;
        endcase
    end

    // Moore outputs: a pure decode of the registered state. Illegal encodings give 0.
    always_comb begin
        Z            = 1'b0;
        change_given = 1'b0;
        case (state_q)
            S40: Z = 1'b1;
            S50, S60, S70, S80: begin
                Z            = 1'b1;
                change_given = 1'b1;
            end
            default: begin
                Z            = 1'b0;
                change_given = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_vending_machine.sv
// Purpose : directed, table-driven bench for vending_machine, plus hand-written
//           sequences for the hold and saturation corner cases.
// Ports   : none. The bench drives clk/reset/coin and checks Z/change_given 1 ns after each edge.
module tb_vending_machine;

    logic       clk;
    logic       reset;
    logic [1:0] coin;
    logic       Z;
    logic       change_given;

    int n_vec;
    int n_err;

    typedef struct {
        logic       rst;
        logic [1:0] coin;
        logic       exp_z;
        logic       exp_chg;
    } vec_t;

    vec_t vecs[$];

    vending_machine dut (
        .clk         (clk),
        .reset       (reset),
        .coin        (coin),
        .Z           (Z),
        .change_given(change_given)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [1:0] c, input logic ez, input logic ec);
        vec_t v;
        v.rst     = r;
        v.coin    = c;
        v.exp_z   = ez;
        v.exp_chg = ec;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic ez, input logic ec);
        n_vec++;
        if (Z !== ez || change_given !== ec) begin
            n_err++;
            $display("FAIL %s: Z=%b change_given=%b, expected Z=%b change_given=%b",
                     name, Z, change_given, ez, ec);
        end
    endtask

    // Drive the inputs away from the edge, then clock once and sample 1 ns later.
    task automatic apply(input string name, input logic r, input logic [1:0] c,
                         input logic ez, input logic ec);
        reset = r;
        coin  = c;
        @(posedge clk);
        #1;
        check(name, ez, ec);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        coin  = 2'b11;
        @(posedge clk);
        #1;
        check("reset_state", 1'b0, 1'b0);

        // Columns: reset, coin, expected Z, expected change_given (after the edge).
        // Plan 1: 10, 20, 10 -> S10, S30, S40
        add(1, 2'b11, 0, 0);
        add(0, 2'b00, 0, 0);
        add(0, 2'b01, 0, 0);
        add(0, 2'b00, 1, 0);
        // Plan 2: one 50 coin -> S50
        add(1, 2'b00, 0, 0);
        add(0, 2'b10, 1, 1);
        // Plan 3: 20, 50 -> S20, S70; then 10 -> S80
        add(1, 2'b11, 0, 0);
        add(0, 2'b01, 0, 0);
        add(0, 2'b10, 1, 1);
        add(0, 2'b00, 1, 1);
        // Plan 4: 10, 50 -> S60; reset clears the flags
        add(1, 2'b11, 0, 0);
        add(0, 2'b00, 0, 0);
        add(0, 2'b10, 1, 1);
        add(1, 2'b11, 0, 0);
        // Exact threshold by 20+20, then 10 more -> S50
        add(0, 2'b01, 0, 0);
        add(0, 2'b01, 1, 0);
        add(0, 2'b00, 1, 1);
        // 10, 20, 20 -> S50, which jumps straight over 40
        add(1, 2'b11, 0, 0);
        add(0, 2'b00, 0, 0);
        add(0, 2'b01, 0, 0);
        add(0, 2'b01, 1, 1);
        // S40 held by a no-coin cycle
        add(1, 2'b11, 0, 0);
        add(0, 2'b01, 0, 0);
        add(0, 2'b01, 1, 0);
        add(0, 2'b11, 1, 0);
        // Plan 6: reset with a 50 coin from S30 ignores the coin. The next 10 gives S10, not S60.
        add(1, 2'b11, 0, 0);
        add(0, 2'b01, 0, 0);
        add(0, 2'b00, 0, 0);
        add(1, 2'b10, 0, 0);
        add(0, 2'b00, 0, 0);
        add(0, 2'b01, 0, 0);
        add(0, 2'b00, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply($sformatf("vec%0d", i), vecs[i].rst, vecs[i].coin,
                  vecs[i].exp_z, vecs[i].exp_chg);
        end

        // Plan 5: reach S30, hold coin=11 for 5 cycles, then add three 50 coins and saturate.
        apply("hold_rst", 1'b1, 2'b11, 1'b0, 1'b0);
        apply("hold_s10", 1'b0, 2'b00, 1'b0, 1'b0);
        apply("hold_s30", 1'b0, 2'b01, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            apply($sformatf("hold_idle%0d", k), 1'b0, 2'b11, 1'b0, 1'b0);
        end
        // Exactly 40 after the hold shows the total stayed at 30.
        apply("hold_s40", 1'b0, 2'b00, 1'b1, 1'b0);
        apply("hold_back_rst", 1'b1, 2'b11, 1'b0, 1'b0);
        apply("hold_b_s10", 1'b0, 2'b00, 1'b0, 1'b0);
        apply("hold_b_s30", 1'b0, 2'b01, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            apply($sformatf("hold_b_idle%0d", k), 1'b0, 2'b11, 1'b0, 1'b0);
        end
        for (int k = 0; k < 3; k++) begin
            apply($sformatf("sat50_%0d", k), 1'b0, 2'b10, 1'b1, 1'b1);
        end
        // S80 + 10/20 stays saturated. Reset then clears the flags.
        apply("sat10", 1'b0, 2'b00, 1'b1, 1'b1);
        apply("sat20", 1'b0, 2'b01, 1'b1, 1'b1);
        apply("sat_rst", 1'b1, 2'b00, 1'b0, 1'b0);
        // After saturation and reset, 10 + 20 must stay below the price.
        apply("post_s10", 1'b0, 2'b00, 1'b0, 1'b0);
        apply("post_s30", 1'b0, 2'b01, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
